// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, opcode constants and sequencer state encoding.
package alu_pkg;

   localparam int unsigned WIDTH = 64;
   localparam int unsigned OP_W  = 3;

   localparam logic [OP_W-1:0] OP_ADD = 3'b000;
   localparam logic [OP_W-1:0] OP_SUB = 3'b001;
   localparam logic [OP_W-1:0] OP_AND = 3'b010;
   localparam logic [OP_W-1:0] OP_XOR = 3'b011;
   localparam logic [OP_W-1:0] OP_NOT = 3'b100;
   localparam logic [OP_W-1:0] OP_NEG = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMPL = 2'd1,
      ST_EXEC = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Ops that need an operand complemented before the execute step.
   function automatic logic is_cmpl_op(input logic [OP_W-1:0] op);
      return (op == OP_SUB) || (op == OP_NOT) || (op == OP_NEG);
   endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request and result valid/ready channels between control side and the ALU sequencer.
interface alu_op_sequencer_if;
   import alu_pkg::*;

   logic                in_valid;
   logic                in_ready;
   logic [OP_W-1:0]     in_op;
   logic [WIDTH-1:0]    in_a;
   logic [WIDTH-1:0]    in_b;
   logic                out_valid;
   logic                out_ready;
   logic [WIDTH-1:0]    out_result;
   logic                out_zero;
   logic                out_ovf;
   logic                out_err;

   modport master (
      output in_valid, in_op, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_result, out_zero, out_ovf, out_err
   );

   modport slave (
      input  in_valid, in_op, in_a, in_b, out_ready,
      output in_ready, out_valid, out_result, out_zero, out_ovf, out_err
   );

endinterface

// File: rtl/bitcompliment.sv
// Shared combinational bitwise complement unit.
module bitcompliment #(
   parameter int unsigned WIDTH = 64
) (
   input  logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] y
);

   assign y = ~a;

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle ALU op sequencer: complement step for SUB/NOT/NEG, then execute, then
// hold the registered result until the consumer takes it.
module alu_op_sequencer
   import alu_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   alu_op_sequencer_if.slave  bus
);

   localparam int unsigned MSB = WIDTH - 1;

   state_t            state;
   state_t            state_nx;
   logic [OP_W-1:0]   op_q;
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic [WIDTH-1:0]  c_q;
   logic [WIDTH-1:0]  cmpl_in;
   logic [WIDTH-1:0]  cmpl_out;
   logic [WIDTH-1:0]  res_c;
   logic              ovf_c;
   logic              err_c;
   logic              accept;

   logic              in_ready_q;
   logic              out_valid_q;
   logic [WIDTH-1:0]  out_result_q;
   logic              out_zero_q;
   logic              out_ovf_q;
   logic              out_err_q;

   assign accept = (state == ST_IDLE) && bus.in_valid;

   // SUB complements b; NOT/NEG complement a.
   assign cmpl_in = (op_q == OP_SUB) ? b_q : a_q;

   bitcompliment #(.WIDTH(WIDTH)) u_cmpl (
      .a (cmpl_in),
      .y (cmpl_out)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (bus.in_valid) state_nx = is_cmpl_op(bus.in_op) ? ST_CMPL : ST_EXEC;
         ST_CMPL: state_nx = ST_EXEC;
         ST_EXEC: state_nx = ST_DONE;
         ST_DONE: if (bus.out_ready) state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // Execute-stage result and flags; overflow from operand/result sign bits.
   always_comb begin
      res_c = '0;
      ovf_c = 1'b0;
      err_c = 1'b0;
      case (op_q)
         OP_ADD: begin
            res_c = a_q + b_q;
            ovf_c = (a_q[MSB] == b_q[MSB]) && (res_c[MSB] != a_q[MSB]);
         end
         OP_SUB: begin
            res_c = a_q + c_q + WIDTH'(1);
            ovf_c = (a_q[MSB] != b_q[MSB]) && (res_c[MSB] != a_q[MSB]);
         end
         OP_AND: res_c = a_q & b_q;
         OP_XOR: res_c = a_q ^ b_q;
         OP_NOT: res_c = c_q;
         OP_NEG: begin
            res_c = c_q + WIDTH'(1);
            ovf_c = (a_q == {1'b1, {(WIDTH-1){1'b0}}});
         end
         default: err_c = 1'b1;
      endcase
   end

   // Operand capture; no reset needed since contents are only used after an accept.
   always_ff @(posedge clk) begin
      if (accept) begin
         op_q <= bus.in_op;
         a_q  <= bus.in_a;
         b_q  <= bus.in_b;
      end
      if (state == ST_CMPL) begin
         c_q <= cmpl_out;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_ready_q   <= 1'b1;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_zero_q   <= 1'b0;
         out_ovf_q    <= 1'b0;
         out_err_q    <= 1'b0;
      end else begin
         in_ready_q  <= (state_nx == ST_IDLE);
         out_valid_q <= (state_nx == ST_DONE);
         if (state == ST_EXEC) begin
            out_result_q <= res_c;
            out_zero_q   <= (res_c == '0);
            out_ovf_q    <= ovf_c;
            out_err_q    <= err_c;
         end
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_result = out_result_q;
   assign bus.out_zero   = out_zero_q;
   assign bus.out_ovf    = out_ovf_q;
   assign bus.out_err    = out_err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized and directed bench for alu_op_sequencer against a transaction-level reference model.
module tb_alu_op_sequencer;
   import alu_pkg::*;

   localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;
   localparam logic [63:0] MAXV = 64'h7FFF_FFFF_FFFF_FFFF;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;
   bit   chk_en = 1'b0;

   always #5 clk = ~clk;

   alu_op_sequencer_if bus ();

   alu_op_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Reference ALU: signed 65-bit arithmetic, overflow = result does not fit in 64 bits.
   function automatic void ref_alu(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                                   output logic [63:0] res, output logic ovf, output logic err);
      logic signed [64:0] sa, sb, full;
      sa  = {a[63], a};
      sb  = {b[63], b};
      res = '0; ovf = 1'b0; err = 1'b0;
      case (op)
         3'd0: begin full = sa + sb; res = full[63:0]; ovf = full[64] != full[63]; end
         3'd1: begin full = sa - sb; res = full[63:0]; ovf = full[64] != full[63]; end
         3'd2: res = a & b;
         3'd3: res = a ^ b;
         3'd4: res = ~a;
         3'd5: begin full = -sa; res = full[63:0]; ovf = full[64] != full[63]; end
         default: err = 1'b1;
      endcase
   endfunction

   // Transaction-level model: outstanding op with a cycle countdown to its result.
   logic        m_ready, m_valid, m_zero, m_ovf, m_err;
   logic [63:0] m_res;
   logic [63:0] p_res;
   logic        p_ovf, p_err;
   int          m_cnt;

   always @(posedge clk) begin
      if (rst) begin
         m_ready = 1'b1; m_valid = 1'b0; m_res = '0;
         m_zero = 1'b0; m_ovf = 1'b0; m_err = 1'b0; m_cnt = 0;
      end else if (m_ready && bus.in_valid) begin
         ref_alu(bus.in_op, bus.in_a, bus.in_b, p_res, p_ovf, p_err);
         m_cnt   = (bus.in_op == 3'd1 || bus.in_op == 3'd4 || bus.in_op == 3'd5) ? 2 : 1;
         m_ready = 1'b0;
      end else if (m_cnt != 0) begin
         m_cnt = m_cnt - 1;
         if (m_cnt == 0) begin
            m_valid = 1'b1; m_res = p_res; m_zero = (p_res == 64'd0);
            m_ovf = p_ovf; m_err = p_err;
         end
      end else if (m_valid && bus.out_ready) begin
         m_valid = 1'b0;
         m_ready = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         vectors++;
         if (bus.in_ready !== m_ready || bus.out_valid !== m_valid || bus.out_result !== m_res ||
             bus.out_zero !== m_zero || bus.out_ovf !== m_ovf || bus.out_err !== m_err) begin
            miscompares++;
            $display("FAIL model t=%0t: dut rdy=%b vld=%b res=%h z=%b o=%b e=%b required rdy=%b vld=%b res=%h z=%b o=%b e=%b",
                     $time, bus.in_ready, bus.out_valid, bus.out_result, bus.out_zero, bus.out_ovf, bus.out_err,
                     m_ready, m_valid, m_res, m_zero, m_ovf, m_err);
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h required %h", nm, got, exp);
      end
   endtask

   // Present a request at a negedge and hold until accepted; returns at the negedge after accept.
   task automatic send(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
      int n;
      bus.in_valid = 1'b1; bus.in_op = op; bus.in_a = a; bus.in_b = b;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("send_timeout", 64'(n), 64'd0);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic chk_out(input string nm, input logic [63:0] r, input logic z, input logic o, input logic e);
      chk({nm, "_valid"}, 64'(bus.out_valid), 64'd1);
      chk({nm, "_result"}, bus.out_result, r);
      chk({nm, "_flags"}, {61'd0, bus.out_zero, bus.out_ovf, bus.out_err}, {61'd0, z, o, e});
   endtask

   logic [63:0] t_res;
   logic        t_ovf, t_err;

   function automatic logic [63:0] pick_val();
      case ($urandom_range(0, 7))
         0: return 64'd0;
         1: return MINV;
         2: return MAXV;
         3: return '1;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      bus.in_valid = 1'b0; bus.in_op = '0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b1;

      // Model pins against hand-computed values.
      ref_alu(3'd4, 64'h8000_0000_0000_0405, 64'd0, t_res, t_ovf, t_err);
      chk("pin_not", t_res, 64'h7FFF_FFFF_FFFF_FBFA);
      ref_alu(3'd1, 64'd3, 64'd5, t_res, t_ovf, t_err);
      chk("pin_sub", t_res, 64'hFFFF_FFFF_FFFF_FFFE);
      ref_alu(3'd5, MINV, 64'd0, t_res, t_ovf, t_err);
      chk("pin_neg", {t_res[63:1], t_ovf}, {MINV[63:1], 1'b1});
      ref_alu(3'd0, MAXV, 64'd1, t_res, t_ovf, t_err);
      chk("pin_add_ovf", 64'(t_ovf), 64'd1);

      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;
      chk("reset_ready", 64'(bus.in_ready), 64'd1);
      chk("reset_outs", {59'd0, bus.out_valid, bus.out_zero, bus.out_ovf, bus.out_err, |bus.out_result}, 64'd0);

      send(3'd0, 64'd5, 64'd7);
      @(negedge clk);
      chk_out("add", 64'd12, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("add_ready_after", 64'(bus.in_ready), 64'd1);

      send(3'd4, 64'h8000_0000_0000_0405, 64'd0);
      repeat (2) @(negedge clk);
      chk_out("not", 64'h7FFF_FFFF_FFFF_FBFA, 1'b0, 1'b0, 1'b0);
      @(negedge clk);

      send(3'd5, MINV, 64'd0);
      repeat (2) @(negedge clk);
      chk_out("neg_min", MINV, 1'b0, 1'b1, 1'b0);
      @(negedge clk);

      send(3'd1, 64'd3, 64'd5);
      repeat (2) @(negedge clk);
      chk_out("sub", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
      @(negedge clk);

      send(3'd1, MAXV, '1);
      repeat (2) @(negedge clk);
      chk_out("sub_ovf", MINV, 1'b0, 1'b1, 1'b0);
      @(negedge clk);

      send(3'd3, 64'hFFF3_E73F_0000_0000, 64'hFFF3_E73F_0000_0000);
      @(negedge clk);
      chk_out("xor", 64'd0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);

      send(3'd7, 64'd9, 64'd4);
      @(negedge clk);
      chk_out("illegal", 64'd0, 1'b1, 1'b0, 1'b1);
      @(negedge clk);

      // Backpressure with a pending request.
      bus.out_ready = 1'b0;
      send(3'd0, 64'd1, 64'd1);
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_op = 3'd2; bus.in_a = 64'hF0F0; bus.in_b = 64'h0FF0;
      for (int i = 0; i < 4; i++) begin
         chk_out("bp_hold", 64'd2, 1'b0, 1'b0, 1'b0);
         chk("bp_ready", 64'(bus.in_ready), 64'd0);
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_released", {62'd0, bus.in_ready, bus.out_valid}, 64'd2);
      @(negedge clk);
      chk("bp_accepted", 64'(bus.in_ready), 64'd0);
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk_out("bp_and", 64'h00F0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);

      // Reset during complement step of a SUB.
      send(3'd1, 64'd100, 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_idle", {62'd0, bus.in_ready, bus.out_valid}, 64'd2);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("abort_no_valid", {63'd0, bus.out_valid}, 64'd0);
      end

      // Randomized traffic, checked every cycle by the model compare.
      for (int i = 0; i < 1500; i++) begin
         bus.in_valid  = ($urandom_range(0, 2) != 0);
         bus.in_op     = 3'($urandom_range(0, 7));
         bus.in_a      = pick_val();
         bus.in_b      = ($urandom_range(0, 5) == 0) ? bus.in_a : pick_val();
         bus.out_ready = ($urandom_range(0, 3) != 0);
         rst           = ($urandom_range(0, 199) == 0);
         @(negedge clk);
      end
      rst = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      repeat (8) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
